// File: rtl/seg_scan_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_scheduler_pkg
// Shared types and constants for the multiplexed 7-segment scan scheduler:
//   scan_state_e  - scan FSM state encoding
//   SEG_LUT       - hex digit to segment pattern (a at [7], dp at [0])
//   DP_BIT        - bit position of the decimal point inside a segment byte
//   seg_decode()  - nibble to segment byte lookup
// ---------------------------------------------------------------------------
package seg_scan_scheduler_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned DP_BIT     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    // Active-high segments a..g,dp; dp is always 0 here and OR-ed in later.
    localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// ---------------------------------------------------------------------------
// seg_scan_scheduler_if
// Two-requester valid/ready bus feeding display words to the scheduler.
//   Req_A_Valid/Req_A_Data/Req_A_Ready - requester A (master drives valid/data)
//   Req_B_Valid/Req_B_Data/Req_B_Ready - requester B, same semantics
//   master modport: requester side; slave modport: scheduler side
// ---------------------------------------------------------------------------
interface seg_scan_scheduler_if;
    import seg_scan_scheduler_pkg::*;

    logic              Req_A_Valid;
    logic [DATA_W-1:0] Req_A_Data;
    logic              Req_A_Ready;
    logic              Req_B_Valid;
    logic [DATA_W-1:0] Req_B_Data;
    logic              Req_B_Ready;

    modport master (
        output Req_A_Valid, Req_A_Data, Req_B_Valid, Req_B_Data,
        input  Req_A_Ready, Req_B_Ready
    );

    modport slave (
        input  Req_A_Valid, Req_A_Data, Req_B_Valid, Req_B_Data,
        output Req_A_Ready, Req_B_Ready
    );

endinterface

// File: rtl/seg_rr_arbiter.sv
// ---------------------------------------------------------------------------
// seg_rr_arbiter
// Round-robin arbiter between two word requesters with a shadow register.
//   clk, rst         - clock, async active-high reset
//   i_a_valid/data   - requester A offer
//   i_b_valid/data   - requester B offer
//   i_commit         - shadow consumed by the display this cycle
//   o_a_ready_c      - combinational ready to A (zero wait states)
//   o_b_ready_c      - combinational ready to B
//   o_shadow         - last accepted word
//   o_shadow_owner   - requester of the last accepted word (0=A, 1=B)
//   o_dirty          - shadow holds a word not yet committed
// ---------------------------------------------------------------------------
module seg_rr_arbiter
    import seg_scan_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_a_valid,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_b_valid,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_commit,
    output logic              o_a_ready_c,
    output logic              o_b_ready_c,
    output logic [DATA_W-1:0] o_shadow,
    output logic              o_shadow_owner,
    output logic              o_dirty
);

    logic              r_ptr;   // 0: A has priority, 1: B has priority
    logic [DATA_W-1:0] r_shadow;
    logic              r_owner;
    logic              r_dirty;
    logic              w_a_grant;
    logic              w_b_grant;

    // Grants are mutually exclusive; held off while reset is asserted.
    always_comb begin
        w_a_grant = !rst && i_a_valid && (!i_b_valid || !r_ptr);
        w_b_grant = !rst && i_b_valid && (!i_a_valid ||  r_ptr);
    end

    // Accept into shadow; a same-cycle accept keeps dirty set over a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= 1'b0;
            r_shadow <= '0;
            r_owner  <= 1'b0;
            r_dirty  <= 1'b0;
        end else if (w_a_grant || w_b_grant) begin
            r_ptr    <= w_a_grant;
            r_shadow <= w_b_grant ? i_b_data : i_a_data;
            r_owner  <= w_b_grant;
            r_dirty  <= 1'b1;
        end else if (i_commit) begin
            r_dirty  <= 1'b0;
        end
    end

    assign o_a_ready_c    = w_a_grant;
    assign o_b_ready_c    = w_b_grant;
    assign o_shadow       = r_shadow;
    assign o_shadow_owner = r_owner;
    assign o_dirty        = r_dirty;

endmodule

// File: rtl/seg_scan_scheduler.sv
// ---------------------------------------------------------------------------
// seg_scan_scheduler
// Four-digit multiplexed 7-segment scan scheduler with two arbitrated
// requesters; new words are shown only from a frame boundary.
//   Sys_CLK  - clock
//   Sys_RST  - async active-high reset
//   EN       - display enable (0 blanks and restarts the scan)
//   DP_Mask  - per-digit decimal point, sampled live
//   bus      - requester A/B valid/ready bus (slave side)
//   COM      - one-hot digit select, registered
//   SEG      - segments a..g,dp (a at [7]), registered
//   Owner    - requester whose word is displayed
// ---------------------------------------------------------------------------
module seg_scan_scheduler
    import seg_scan_scheduler_pkg::*;
#(
    parameter int unsigned DIV_MAX   = 5000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                  Sys_CLK,
    input  logic                  Sys_RST,
    input  logic                  EN,
    input  logic [NUM_DIGITS-1:0] DP_Mask,
    seg_scan_scheduler_if.slave   bus,
    output logic [NUM_DIGITS-1:0] COM,
    output logic [SEG_W-1:0]      SEG,
    output logic                  Owner
);

    // One counter serves both slot and blank phases; BLANK_CYC fits 8 bits.
    localparam int unsigned DIV_W = $clog2(DIV_MAX + 1);
    localparam int unsigned CNT_W = (DIV_W > 8) ? DIV_W : 8;

    scan_state_e           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_idx;
    logic [DATA_W-1:0]     r_buf;
    logic                  r_owner;
    logic [NUM_DIGITS-1:0] r_com;
    logic [SEG_W-1:0]      r_seg;

    scan_state_e           w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [1:0]            w_idx_nxt;
    logic                  w_commit;
    logic [DATA_W-1:0]     w_buf_nxt;
    logic                  w_owner_nxt;
    logic [NUM_DIGITS-1:0] w_com_nxt;
    logic [SEG_W-1:0]      w_seg_nxt;
    logic [DATA_W-1:0]     w_shadow;
    logic                  w_shadow_owner;
    logic                  w_dirty;
    logic                  w_a_ready;
    logic                  w_b_ready;

    seg_rr_arbiter u_arb (
        .clk            (Sys_CLK),
        .rst            (Sys_RST),
        .i_a_valid      (bus.Req_A_Valid),
        .i_a_data       (bus.Req_A_Data),
        .i_b_valid      (bus.Req_B_Valid),
        .i_b_data       (bus.Req_B_Data),
        .i_commit       (w_commit),
        .o_a_ready_c    (w_a_ready),
        .o_b_ready_c    (w_b_ready),
        .o_shadow       (w_shadow),
        .o_shadow_owner (w_shadow_owner),
        .o_dirty        (w_dirty)
    );

    assign bus.Req_A_Ready = w_a_ready;
    assign bus.Req_B_Ready = w_b_ready;

    // Next state, frame-boundary commit and next registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_com_nxt   = '0;
        w_seg_nxt   = '0;

        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (EN) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (r_cnt == CNT_W'(DIV_MAX)) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BLANK: begin
                if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                    w_state_nxt = ST_SCAN;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase

        // Disable wins from any state; the interrupted slot is abandoned.
        if (!EN) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end

        // Frame boundary: entering SCAN on digit 0 from IDLE or BLANK.
        w_commit    = w_dirty && (w_state_nxt == ST_SCAN) &&
                      (r_state != ST_SCAN) && (w_idx_nxt == 2'd0);
        w_buf_nxt   = w_commit ? w_shadow       : r_buf;
        w_owner_nxt = w_commit ? w_shadow_owner : r_owner;

        if (w_state_nxt == ST_SCAN) begin
            w_com_nxt         = NUM_DIGITS'(1) << w_idx_nxt;
            w_seg_nxt         = seg_decode(w_buf_nxt[{w_idx_nxt, 2'b00} +: 4]);
            w_seg_nxt[DP_BIT] = w_seg_nxt[DP_BIT] | DP_Mask[w_idx_nxt];
        end
    end

    // State, display buffer and output registers.
    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_buf   <= '0;
            r_owner <= 1'b0;
            r_com   <= '0;
            r_seg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_buf   <= w_buf_nxt;
            r_owner <= w_owner_nxt;
            r_com   <= w_com_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign COM   = r_com;
    assign SEG   = r_seg;
    assign Owner = r_owner;

endmodule
